// File: rtl/int_seq_pkg.sv
// Shared encodings and default vectors for the interrupt entry sequencer.
package int_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned ADDR_W  = 16;

  // State code doubles as the externally visible cyc value.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5,
    ST_S6   = 3'd6
  } state_t;

  typedef enum logic [SRC_W-1:0] {
    SRC_RST = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } src_t;

  localparam logic [ADDR_W-1:0] DEF_VEC_NMI = 16'hFFFA;
  localparam logic [ADDR_W-1:0] DEF_VEC_RST = 16'hFFFC;
  localparam logic [ADDR_W-1:0] DEF_VEC_IRQ = 16'hFFFE;

  // Control bundle ORed into the decoder lines while busy.
  typedef struct packed {
    logic               busy;
    logic [STATE_W-1:0] cyc;
    logic               rw;
    logic               push_pch;
    logic               push_pcl;
    logic               push_p;
    logic               b_bit;
    logic               spdec;
    logic               setreset;
    logic               setnmi;
    logic               setirq;
    logic [ADDR_W-1:0]  vec_addr;
    logic               set_i;
    logic               done;
  } ctl_t;

  // Output image of S1 for a reset entry, held while clr is low.
  localparam ctl_t CTL_RESET = '{busy: 1'b1, cyc: 3'd1, rw: 1'b1, default: '0};

endpackage

// File: rtl/int_sequencer_nmi_edge_latch.sv
// NMI rising-edge detector with a set/clear pending latch.
module nmi_edge_latch (
  input  logic clk,
  input  logic clr,
  input  logic nmi,
  input  logic clear,
  output logic pending
);

  logic nmi_prev;
  logic rise;

  assign rise = nmi & ~nmi_prev;

  // A new edge wins over a simultaneous clear so it is not lost.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      nmi_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      nmi_prev <= nmi;
      pending  <= rise | (pending & ~clear);
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// 6502 reset/NMI/IRQ/BRK entry sequencer: arbitration and 7-cycle stack/vector sequence.
module int_sequencer
  import int_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] VEC_NMI = DEF_VEC_NMI,
  parameter logic [ADDR_W-1:0] VEC_RST = DEF_VEC_RST,
  parameter logic [ADDR_W-1:0] VEC_IRQ = DEF_VEC_IRQ
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               irq,
  input  logic               nmi,
  input  logic               brk_req,
  input  logic               sync,
  input  logic               iflag,
  output logic               busy,
  output logic [STATE_W-1:0] cyc,
  output logic               rw,
  output logic               push_pch,
  output logic               push_pcl,
  output logic               push_p,
  output logic               b_bit,
  output logic               spdec,
  output logic               setreset,
  output logic               setnmi,
  output logic               setirq,
  output logic [ADDR_W-1:0]  vec_addr,
  output logic               set_i,
  output logic               done
);

  state_t            state_q, state_d;
  src_t              src_q, src_d;     // source that started the entry (drives b_bit)
  src_t              vsrc_q, vsrc_d;   // source whose vector is fetched (may become NMI)
  ctl_t              ctl_q, ctl_d;
  logic              nmi_pend;
  logic              nmi_clear;
  logic              use_nmi;
  logic              do_push;
  logic [ADDR_W-1:0] vec_base;

  nmi_edge_latch u_nmi_latch (
    .clk     (clk),
    .clr     (clr),
    .nmi     (nmi),
    .clear   (nmi_clear),
    .pending (nmi_pend)
  );

  // Next state, source tracking and registered-output image.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    vsrc_d    = vsrc_q;
    use_nmi   = (src_q == SRC_NMI) || ((src_q != SRC_RST) && nmi_pend);
    nmi_clear = 1'b0;
    vec_base  = VEC_IRQ;
    do_push   = 1'b0;
    ctl_d     = '0;
    ctl_d.rw  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (sync) begin
          if (nmi_pend) begin
            state_d = ST_S1;
            src_d   = SRC_NMI;
            vsrc_d  = SRC_NMI;
          end else if (irq && !iflag) begin
            state_d = ST_S1;
            src_d   = SRC_IRQ;
            vsrc_d  = SRC_IRQ;
          end else if (brk_req) begin
            state_d = ST_S1;
            src_d   = SRC_BRK;
            vsrc_d  = SRC_BRK;
          end
        end
      end
      ST_S1: state_d = ST_S2;
      ST_S2: state_d = ST_S3;
      ST_S3: state_d = ST_S4;
      ST_S4: begin
        // Last chance for an NMI to hijack an IRQ/BRK vector fetch.
        state_d   = ST_S5;
        vsrc_d    = use_nmi ? SRC_NMI : src_q;
        nmi_clear = use_nmi;
      end
      ST_S5:   state_d = ST_S6;
      ST_S6:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case (vsrc_d)
      SRC_RST: vec_base = VEC_RST;
      SRC_NMI: vec_base = VEC_NMI;
      default: vec_base = VEC_IRQ;
    endcase

    do_push     = (src_d != SRC_RST);
    ctl_d.busy  = (state_d != ST_IDLE);
    ctl_d.cyc   = STATE_W'(state_d);
    ctl_d.b_bit = ctl_d.busy && (src_d == SRC_BRK);

    case (state_d)
      ST_S2: begin
        ctl_d.spdec    = 1'b1;
        ctl_d.rw       = ~do_push;
        ctl_d.push_pch = do_push;
      end
      ST_S3: begin
        ctl_d.spdec    = 1'b1;
        ctl_d.rw       = ~do_push;
        ctl_d.push_pcl = do_push;
      end
      ST_S4: begin
        ctl_d.spdec    = 1'b1;
        ctl_d.rw       = ~do_push;
        ctl_d.push_p   = do_push;
      end
      ST_S5: begin
        ctl_d.vec_addr = vec_base;
        ctl_d.setreset = (vsrc_d == SRC_RST);
        ctl_d.setnmi   = (vsrc_d == SRC_NMI);
        ctl_d.setirq   = (vsrc_d == SRC_IRQ) || (vsrc_d == SRC_BRK);
      end
      ST_S6: begin
        ctl_d.vec_addr = vec_base + ADDR_W'(1);
        ctl_d.setreset = (vsrc_d == SRC_RST);
        ctl_d.setnmi   = (vsrc_d == SRC_NMI);
        ctl_d.setirq   = (vsrc_d == SRC_IRQ) || (vsrc_d == SRC_BRK);
        ctl_d.set_i    = 1'b1;
        ctl_d.done     = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; reset parks in S1 of a reset entry.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_S1;
      src_q   <= SRC_RST;
      vsrc_q  <= SRC_RST;
      ctl_q   <= CTL_RESET;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      vsrc_q  <= vsrc_d;
      ctl_q   <= ctl_d;
    end
  end

  assign busy     = ctl_q.busy;
  assign cyc      = ctl_q.cyc;
  assign rw       = ctl_q.rw;
  assign push_pch = ctl_q.push_pch;
  assign push_pcl = ctl_q.push_pcl;
  assign push_p   = ctl_q.push_p;
  assign b_bit    = ctl_q.b_bit;
  assign spdec    = ctl_q.spdec;
  assign setreset = ctl_q.setreset;
  assign setnmi   = ctl_q.setnmi;
  assign setirq   = ctl_q.setirq;
  assign vec_addr = ctl_q.vec_addr;
  assign set_i    = ctl_q.set_i;
  assign done     = ctl_q.done;

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: a plan-based entry model feeds expected output images.
module tb_int_sequencer;

  localparam int T_RST = 0;
  localparam int T_NMI = 1;
  localparam int T_IRQ = 2;
  localparam int T_BRK = 3;

  typedef struct packed {
    logic        busy;
    logic [2:0]  cyc;
    logic        rw;
    logic        push_pch;
    logic        push_pcl;
    logic        push_p;
    logic        b_bit;
    logic        spdec;
    logic        setreset;
    logic        setnmi;
    logic        setirq;
    logic [15:0] vec_addr;
    logic        set_i;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  logic clr, irq, nmi, brk_req, sync, iflag;
  logic        busy, rw, push_pch, push_pcl, push_p, b_bit, spdec;
  logic        setreset, setnmi, setirq, set_i, done;
  logic [2:0]  cyc;
  logic [15:0] vec_addr;

  int checks   = 0;
  int failures = 0;
  int phase    = 0;

  obs_t exp_q[$];
  int   tag_q[$];

  // Reference model state: remaining cycles of the current entry, NMI bookkeeping.
  obs_t plan[$];
  int   cur_src;
  bit   m_pend;
  bit   m_prev;

  int_sequencer dut (
    .clk(clk), .clr(clr), .irq(irq), .nmi(nmi), .brk_req(brk_req), .sync(sync),
    .iflag(iflag), .busy(busy), .cyc(cyc), .rw(rw), .push_pch(push_pch),
    .push_pcl(push_pcl), .push_p(push_p), .b_bit(b_bit), .spdec(spdec),
    .setreset(setreset), .setnmi(setnmi), .setirq(setirq), .vec_addr(vec_addr),
    .set_i(set_i), .done(done)
  );

  always #5 clk = ~clk;

  function automatic obs_t idle_img();
    obs_t e = '0;
    e.rw = 1'b1;
    return e;
  endfunction

  // Expected bus image of step k (1..6) of an entry started by src, vectoring through fin.
  function automatic obs_t entry(int k, int src, int fin);
    obs_t e = '0;
    logic [15:0] base;
    base = (fin == T_NMI) ? 16'hFFFA : (fin == T_RST) ? 16'hFFFC : 16'hFFFE;
    e.busy  = 1'b1;
    e.cyc   = 3'(k);
    e.rw    = 1'b1;
    e.b_bit = (src == T_BRK);
    if (k >= 2 && k <= 4) begin
      e.spdec = 1'b1;
      if (src != T_RST) begin
        e.rw       = 1'b0;
        e.push_pch = (k == 2);
        e.push_pcl = (k == 3);
        e.push_p   = (k == 4);
      end
    end
    if (k >= 5) begin
      e.setreset = (fin == T_RST);
      e.setnmi   = (fin == T_NMI);
      e.setirq   = (fin == T_IRQ) || (fin == T_BRK);
      e.vec_addr = base + 16'(k - 5);
    end
    if (k == 6) begin
      e.set_i = 1'b1;
      e.done  = 1'b1;
    end
    return e;
  endfunction

  task automatic start_entry(input int src);
    cur_src = src;
    plan.delete();
    for (int k = 1; k <= 6; k++) plan.push_back(entry(k, src, src));
  endtask

  task automatic model_reset();
    start_entry(T_RST);
    m_pend = 1'b0;
    m_prev = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs held during it.
  task automatic model_edge();
    bit rise;
    bit clr_nmi;
    clr_nmi = 1'b0;
    if (!clr) begin
      model_reset();
    end else begin
      rise   = nmi && !m_prev;
      m_prev = nmi;
      if (plan.size() != 0) begin
        if (plan.size() == 3 && (cur_src == T_NMI || (cur_src != T_RST && m_pend))) begin
          plan[1] = entry(5, cur_src, T_NMI);
          plan[2] = entry(6, cur_src, T_NMI);
          clr_nmi = 1'b1;
        end
        plan.delete(0);
      end else if (sync) begin
        if (m_pend)              start_entry(T_NMI);
        else if (irq && !iflag)  start_entry(T_IRQ);
        else if (brk_req)        start_entry(T_BRK);
      end
      m_pend = rise || (m_pend && !clr_nmi);
    end
  endtask

  // One clock of stimulus; expectation for the following sample is queued.
  task automatic tick(input logic c, input logic i, input logic n, input logic b,
                      input logic s, input logic f);
    @(posedge clk);
    #1;
    model_edge();
    clr = c; irq = i; nmi = n; brk_req = b; sync = s; iflag = f;
    if (!clr) model_reset();
    exp_q.push_back(plan.size() != 0 ? plan[0] : idle_img());
    tag_q.push_back(phase);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare the DUT image against the scoreboard on the falling edge.
  always @(negedge clk) begin
    obs_t got;
    obs_t want;
    int   tg;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      tg   = tag_q.pop_front();
      got  = {busy, cyc, rw, push_pch, push_pcl, push_p, b_bit, spdec,
              setreset, setnmi, setirq, vec_addr, set_i, done};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL ctl phase=%0d t=%0t got=%h (cyc=%0d va=%h) expected=%h (cyc=%0d va=%h)",
                 tg, $time, got, got.cyc, got.vec_addr, want, want.cyc, want.vec_addr);
      end
    end
  end

  initial begin
    clr = 1'b0; irq = 1'b0; nmi = 1'b0; brk_req = 1'b0; sync = 1'b0; iflag = 1'b1;
    model_reset();

    // Reset held, then released: full reset entry through FFFC/FFFD.
    phase = 1;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (busy !== 1'b1 || cyc !== 3'd1 || rw !== 1'b1 || push_pch !== 1'b0 ||
        push_pcl !== 1'b0 || push_p !== 1'b0 || b_bit !== 1'b0 || spdec !== 1'b0 ||
        setreset !== 1'b0 || setnmi !== 1'b0 || setirq !== 1'b0 ||
        vec_addr !== 16'h0000 || set_i !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset state t=%0t busy=%b cyc=%0d rw=%b va=%h", $time, busy, cyc, rw, vec_addr);
    end
    idle(9);

    // IRQ masked by iflag, then unmasked.
    phase = 2;
    repeat (3) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (7) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Software BRK.
    phase = 3;
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(8);

    // IRQ hijacked by an NMI edge during S3; later syncs start nothing.
    phase = 4;
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // NMI beats a pending IRQ; IRQ follows at the next sync.
    phase = 5;
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (7) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted while an IRQ entry is in S4.
    phase = 6;
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fork
      idle(9);
      begin
        int waited;
        waited = 0;
        while (done !== 1'b1 && waited < 12) begin
          @(negedge clk);
          waited++;
        end
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL timeout waiting for done after reset release t=%0t", $time);
        end
      end
    join

    // Random traffic on every input.
    phase = 7;
    for (int n = 0; n < 400; n++) begin
      logic c, i, m, b, s, f;
      c = ($urandom_range(0, 59) != 0);
      i = ($urandom_range(0, 3) == 0) ? ~irq : irq;
      m = ($urandom_range(0, 5) == 0) ? ~nmi : nmi;
      b = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 2) == 0);
      f = 1'($urandom_range(0, 1));
      tick(c, i, m, b, s, f);
    end
    idle(8);

    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
